// File: rtl/pds_target.sv
// PDS bus slave: three R/W 16-bit registers plus a read-only card ID in an
// 8-byte window, with programmable wait states before DTACK.
module pds_target #(
  parameter logic [20:0] BASE_ADDR   = 21'h1E0000,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] CARD_ID     = 16'h5E30
) (
  input  logic        pdsC8m,
  input  logic        pdsReset,
  input  logic        npdsAs,
  input  logic        npdsUds,
  input  logic        npdsLds,
  input  logic        pdsRnW,
  input  logic [23:1] pdsAddr,
  input  logic [15:0] pdsDataIn,
  output logic [15:0] pdsDataOut,
  output logic        pdsDataOe,
  output logic        npdsDtack,
  output logic        targetBusy
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [3:0]  waitCount;
  logic [1:0]  asSync, udsSync, ldsSync;
  logic        asS, udsS, ldsS;
  logic        armed;
  logic        hit;
  logic        loadCount, decCount, enterAck, leaveAck;
  logic [2:0][15:0] regFile;
  logic [15:0] rdData;

  // Strobes are asynchronous to C8M; everything downstream uses the synced copies.
  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset) begin
      asSync  <= 2'b11;
      udsSync <= 2'b11;
      ldsSync <= 2'b11;
    end else begin
      asSync  <= {asSync[0], npdsAs};
      udsSync <= {udsSync[0], npdsUds};
      ldsSync <= {ldsSync[0], npdsLds};
    end
  end

  assign asS  = asSync[1];
  assign udsS = udsSync[1];
  assign ldsS = ldsSync[1];

  assign hit = !asS && (!udsS || !ldsS) && (pdsAddr[23:3] == BASE_ADDR);

  // A bus cycle is only accepted once AS has been seen high since the last one.
  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset)       armed <= 1'b0;
    else if (asS)       armed <= 1'b1;
    else if (loadCount) armed <= 1'b0;
  end

  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    loadCount = 1'b0;
    decCount  = 1'b0;
    enterAck  = 1'b0;
    leaveAck  = 1'b0;
    case (state)
      IDLE: if (hit && armed) begin
        stateNext = WAIT;
        loadCount = 1'b1;
      end
      WAIT: begin
        if (asS) begin
          stateNext = IDLE;
        end else if (waitCount == 4'd0) begin
          stateNext = ACK;
          enterAck  = 1'b1;
        end else begin
          decCount = 1'b1;
        end
      end
      ACK: if (asS) begin
        stateNext = IDLE;
        leaveAck  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset)       waitCount <= 4'd0;
    else if (loadCount) waitCount <= WAIT_INIT;
    else if (decCount)  waitCount <= waitCount - 4'd1;
  end

  always_comb begin
    case (pdsAddr[2:1])
      2'd0:    rdData = regFile[0];
      2'd1:    rdData = regFile[1];
      2'd2:    rdData = regFile[2];
      default: rdData = CARD_ID;
    endcase
  end

  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset) begin
      npdsDtack  <= 1'b1;
      pdsDataOe  <= 1'b0;
      pdsDataOut <= 16'h0000;
    end else if (enterAck) begin
      npdsDtack <= 1'b0;
      pdsDataOe <= pdsRnW;
      if (pdsRnW) pdsDataOut <= rdData;
    end else if (leaveAck) begin
      npdsDtack <= 1'b1;
      pdsDataOe <= 1'b0;
    end
  end

  // Byte lanes are taken from the strobes as synced on the ACK-entry edge only.
  always_ff @(posedge pdsC8m or posedge pdsReset) begin
    if (pdsReset) begin
      regFile <= '0;
    end else if (enterAck && !pdsRnW) begin
      for (int i = 0; i < 3; i++) begin
        if (pdsAddr[2:1] == 2'(i)) begin
          if (!udsS) regFile[i][15:8] <= pdsDataIn[15:8];
          if (!ldsS) regFile[i][7:0]  <= pdsDataIn[7:0];
        end
      end
    end
  end

  assign targetBusy = (state != IDLE);

endmodule

// File: tb/tb_pds_target.sv
// Scoreboard bench for pds_target: directed bus cycles push expectations,
// a monitor compares each DTACK assertion against the queue.
module tb_pds_target;

  logic        pdsC8m = 1'b0;
  logic        pdsReset;
  logic        npdsAs, npdsUds, npdsLds, pdsRnW;
  logic [23:1] pdsAddr;
  logic [15:0] pdsDataIn;
  logic [15:0] pdsDataOut;
  logic        pdsDataOe, npdsDtack, targetBusy;

  pds_target dut (
    .pdsC8m     (pdsC8m),
    .pdsReset   (pdsReset),
    .npdsAs     (npdsAs),
    .npdsUds    (npdsUds),
    .npdsLds    (npdsLds),
    .pdsRnW     (pdsRnW),
    .pdsAddr    (pdsAddr),
    .pdsDataIn  (pdsDataIn),
    .pdsDataOut (pdsDataOut),
    .pdsDataOe  (pdsDataOe),
    .npdsDtack  (npdsDtack),
    .targetBusy (targetBusy)
  );

  always #5 pdsC8m = ~pdsC8m;

  typedef struct {
    logic        rnw;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every falling DTACK must match the oldest outstanding expectation.
  logic prevDtack = 1'b1;
  always @(negedge pdsC8m) begin
    if (prevDtack && npdsDtack === 1'b0) begin
      if (expQ.size() == 0) begin
        check("unexpected_dtack", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("data_oe", {15'd0, pdsDataOe}, {15'd0, e.rnw});
        if (e.rnw) check("read_data", pdsDataOut, e.data);
      end
    end
    prevDtack = npdsDtack;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge pdsC8m);
  endtask

  task automatic releaseBus();
    npdsAs  = 1'b1;
    npdsUds = 1'b1;
    npdsLds = 1'b1;
  endtask

  // One bus cycle; byteAddr is a 24-bit byte address.
  task automatic busCycle(input logic [23:0] byteAddr, input logic rnw,
                          input logic uds, input logic lds,
                          input logic [15:0] wdata, input logic expectAck,
                          input logic [15:0] rdExp);
    int  cyc;
    bit  seen;
    exp_t e;
    @(negedge pdsC8m);
    pdsAddr   = byteAddr[23:1];
    pdsRnW    = rnw;
    pdsDataIn = wdata;
    npdsAs    = 1'b0;
    npdsUds   = uds;
    npdsLds   = lds;
    if (expectAck) begin
      e.rnw = rnw;
      e.data = rdExp;
      expQ.push_back(e);
    end
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge pdsC8m);
      if (npdsDtack === 1'b0 || pdsDataOe === 1'b1) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
    end
    if (expectAck) begin
      // 2 sync edges + 1 hit edge + WAIT_STATES + 1
      check("ack_latency", 16'(cyc), 16'd6);
    end else begin
      check("miss_no_dtack", {15'd0, seen}, 16'd0);
    end
    releaseBus();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pdsC8m);
      if (npdsDtack === 1'b1 && targetBusy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("release_idle", {15'd0, seen}, 16'd1);
    idle(1);
  endtask

  task automatic rd(input logic [23:0] a, input logic [15:0] exp);
    busCycle(a, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, exp);
  endtask

  task automatic wr(input logic [23:0] a, input logic uds, input logic lds, input logic [15:0] d);
    busCycle(a, 1'b0, uds, lds, d, 1'b1, 16'h0000);
  endtask

  initial begin
    bit seen;
    pdsReset  = 1'b1;
    releaseBus();
    pdsRnW    = 1'b1;
    pdsAddr   = '0;
    pdsDataIn = '0;
    idle(3);
    check("rst_dtack", {15'd0, npdsDtack},  16'd1);
    check("rst_oe",    {15'd0, pdsDataOe},  16'd0);
    check("rst_dout",  pdsDataOut,          16'h0000);
    check("rst_busy",  {15'd0, targetBusy}, 16'd0);
    pdsReset = 1'b0;
    idle(3);

    // Word write then read back
    wr(24'hF00002, 1'b0, 1'b0, 16'hA55A);
    rd(24'hF00002, 16'hA55A);

    // Byte lanes on reg0
    wr(24'hF00000, 1'b0, 1'b0, 16'h1234);
    wr(24'hF00000, 1'b1, 1'b0, 16'hFFCD);
    rd(24'hF00000, 16'h12CD);
    wr(24'hF00000, 1'b0, 1'b1, 16'hEFFF);
    rd(24'hF00000, 16'hEFCD);

    // ID register is read-only
    rd(24'hF00006, 16'h5E30);
    wr(24'hF00006, 1'b0, 1'b0, 16'h0000);
    rd(24'hF00006, 16'h5E30);

    // reg2 and misses
    wr(24'hF00004, 1'b0, 1'b0, 16'hC3C3);
    busCycle(24'hF00008, 1'b0, 1'b0, 1'b0, 16'hDEAD, 1'b0, 16'h0000);
    busCycle(24'hE00000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0, 16'h0000);
    rd(24'hF00000, 16'hEFCD);
    rd(24'hF00002, 16'hA55A);
    rd(24'hF00004, 16'hC3C3);

    // Abort: AS dropped as soon as the FSM enters WAIT
    @(negedge pdsC8m);
    pdsAddr = 23'h780001;  // byte 0xF00002
    pdsRnW = 1'b0;
    pdsDataIn = 16'h0F0F;
    npdsAs = 1'b0;
    npdsUds = 1'b0;
    npdsLds = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pdsC8m);
      if (targetBusy === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_enter_wait", {15'd0, seen}, 16'd1);
    releaseBus();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pdsC8m);
      if (npdsDtack === 1'b0) seen = 1'b1;
    end
    check("abort_no_dtack", {15'd0, seen}, 16'd0);
    check("abort_idle", {15'd0, targetBusy}, 16'd0);
    rd(24'hF00002, 16'hA55A);

    // Reset while DTACK is held in a read
    @(negedge pdsC8m);
    pdsAddr = 23'h780001;
    pdsRnW = 1'b1;
    npdsAs = 1'b0;
    npdsUds = 1'b0;
    npdsLds = 1'b0;
    begin
      exp_t e;
      e.rnw = 1'b1;
      e.data = 16'hA55A;
      expQ.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pdsC8m);
      if (npdsDtack === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_ack_reached", {15'd0, seen}, 16'd1);
    #1 pdsReset = 1'b1;
    #1;
    check("rst_ack_dtack", {15'd0, npdsDtack},  16'd1);
    check("rst_ack_oe",    {15'd0, pdsDataOe},  16'd0);
    check("rst_ack_dout",  pdsDataOut,          16'h0000);
    check("rst_ack_busy",  {15'd0, targetBusy}, 16'd0);
    releaseBus();
    idle(2);
    pdsReset = 1'b0;
    idle(3);
    rd(24'hF00000, 16'h0000);
    rd(24'hF00002, 16'h0000);
    rd(24'hF00004, 16'h0000);
    rd(24'hF00006, 16'h5E30);

    idle(5);
    check("queue_drained", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pds_target.md
PDS_TARGET -- requirements
Module: pds_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 21'h1E0000, giving A23:3 match value (window 0xF00000-0xF00007).
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0-15: extra C8M cycles before DTACK.
REQ-003 SHALL have parameter CARD_ID, default 16'h5E30, the read-only ID register value.
REQ-004 SHALL have port pdsC8m, input, 1 bit: 8MHz system clock, the only clock.
REQ-005 SHALL have port pdsReset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port npdsAs, input, 1 bit: PDS address strobe, active-low, asynchronous to pdsC8m.
REQ-007 SHALL have ports npdsUds and npdsLds, input, 1 bit each: PDS upper and lower data strobes, active-low, asynchronous.
REQ-008 SHALL have port pdsRnW, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have port pdsAddr, input, [23:1]: PDS address.
REQ-010 SHALL have port pdsDataIn, input, [15:0]: PDS write data.
REQ-011 SHALL have port pdsDataOut, output, [15:0]: read data.
REQ-012 SHALL have port pdsDataOe, output, 1 bit: 1 = drive pdsDataOut onto the PDS data bus.
REQ-013 SHALL have port npdsDtack, output, 1 bit: 0 = assert DTACK, 1 = release (top level tristates).
REQ-014 SHALL have port targetBusy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 SHALL pass npdsAs, npdsUds and npdsLds each through a 2-flop synchronizer on pdsC8m; the FSM SHALL use only the synchronized copies.
REQ-016 SHALL implement a register file: reg0-reg2 (16-bit read/write) at A2:1 = 0-2; ID at A2:1 = 3 (reads CARD_ID; writes ignored).
REQ-017 SHALL define hit as: synced AS low, at least one synced DS low, and pdsAddr[23:3] == BASE_ADDR.
REQ-018 SHALL implement the FSM as IDLE -> WAIT -> ACK -> IDLE; the encoding of unused states SHALL recover to IDLE.
REQ-019 In IDLE, SHALL go to WAIT on an edge with hit, loading waitCount = WAIT_STATES; SHALL stay in IDLE otherwise.
REQ-020 In WAIT, SHALL go to ACK when waitCount == 0, else decrement; SHALL go to IDLE with no register write if synced AS goes high (abort).
REQ-021 On the edge entering ACK, SHALL latch the addressed register into pdsDataOut for a read.
REQ-022 On the edge entering ACK, SHALL perform a write once: synced UDS low writes [15:8]; synced LDS low writes [7:0]; both low writes the full word.
REQ-023 Byte lanes SHALL be sampled on the ACK-entry edge; a lane strobe arriving later in ACK SHALL NOT write.
REQ-024 In ACK, SHALL hold npdsDtack=0 and, if pdsRnW=1, pdsDataOe=1.
REQ-025 In ACK, SHALL return to IDLE on the first edge with synced AS high; npdsDtack and pdsDataOe SHALL be registered and go to 1 and 0 on that same edge.
REQ-026 Latency: hit first sampled at edge E0 -> ACK entered and npdsDtack=0 at edge E0+WAIT_STATES+1.
REQ-027 Accesses outside the window SHALL never assert npdsDtack or pdsDataOe and SHALL leave the registers unchanged.
REQ-028 After leaving ACK, a new hit SHALL NOT be accepted until synced AS has been seen high for at least one edge (no double-acknowledge of one cycle).
REQ-029 For WAIT_STATES=0, the FSM SHALL spend exactly 1 cycle in WAIT.

Reset
REQ-030 pdsReset high SHALL force, asynchronously: IDLE, waitCount=0, synchronizers=1, npdsDtack=1, pdsDataOe=0, pdsDataOut=16'h0000, targetBusy=0, reg0-reg2=16'h0000.
REQ-031 Reset asserted in WAIT or ACK SHALL abort the cycle with no write and release DTACK immediately.
REQ-032 After reset is released, the first hit SHALL be accepted only on an edge where synced AS is low.

Verification
REQ-033 Word write then read: write 16'hA55A to 0xF00002, then read 0xF00002 -> pdsDataOut=16'hA55A, pdsDataOe=1, npdsDtack=0 at E0+3 (WAIT_STATES=2).
REQ-034 Byte lanes: reg0=16'h1234, then LDS-only write of 16'hFFCD -> reg0=16'h12CD; UDS-only write of 16'hEFFF -> reg0=16'hEFCD.
REQ-035 ID register: read 0xF00006 -> 16'h5E30; write 16'h0000 to it, then read again -> still 16'h5E30.
REQ-036 Miss: write to 0xF00008 and 0xE00000 -> npdsDtack stays 1 for 20 cycles; reg0-reg2 unchanged.
REQ-037 Abort: deassert AS after 1 cycle in WAIT during a write -> FSM returns to IDLE, no DTACK, register unchanged.
REQ-038 Reset mid-ACK: assert pdsReset while npdsDtack=0 -> npdsDtack=1, pdsDataOe=0 immediately, registers=0.
